// File: rtl/bus_initiator_6502.sv
// Command-FIFO-fed initiator for a 6502-style peripheral bus: writes issue back to back, reads are
// single-outstanding with data returned RD_LAT cycles after issue. Option macro: BUS_INITIATOR_IRQ_EN.
module bus_initiator_6502 #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RD_LAT     = 2
) (
    input  logic       phi2,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_we,
    input  logic       cmd_rs0,
    input  logic [9:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [9:0] A,
    output logic       RS0,
    output logic       we_n,
    output logic       CS1,
    output logic [7:0] DO,
    output logic       OE,
    input  logic [7:0] DI,
`ifdef BUS_INITIATOR_IRQ_EN
    input  logic       irq_n,
    input  logic       irq_clr,
    output logic       irq_pending,
`endif
    output logic       busy
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

    typedef struct packed {
        logic       we;
        logic       rs0;
        logic [9:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_t;

    state_t      state_q, state_d;
    cmd_t        mem_q [FIFO_DEPTH];
    cmd_t        cmd_in, head;
    logic [PW:0] wr_ptr_q, rd_ptr_q;
    logic        empty, full, push, pop, load, capture, clr_we;
    logic [1:0]  cnt_q, cnt_d;
    logic [9:0]  addr_q;
    logic        rs0_q, we_n_q;
    logic [7:0]  do_q, rsp_data_q;

    assign cmd_in = '{we: cmd_we, rs0: cmd_rs0, addr: cmd_addr, wdata: cmd_wdata};
    assign head   = mem_q[rd_ptr_q[PW-1:0]];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    // Same slot index with differing wrap bits means the writer has lapped the reader.
    assign full   = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign push   = cmd_valid && !full;

    always_ff @(posedge phi2) begin
        if (push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= cmd_in;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        load    = 1'b0;
        capture = 1'b0;
        clr_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (!we_n_q) begin
                    if (!empty) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        clr_we  = 1'b1;
                        state_d = StIdle;
                    end
                end else if (RD_LAT == 1) begin
                    capture = 1'b1;
                    state_d = StResp;
                end else begin
                    // WAIT lasts RD_LAT-1 cycles; the counter holds the remaining extra cycles.
                    cnt_d   = 2'(RD_LAT - 2);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 2'd0) begin
                    capture = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 2'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            addr_q     <= 10'd0;
            rs0_q      <= 1'b0;
            we_n_q     <= 1'b1;
            do_q       <= 8'd0;
            rsp_data_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (load) begin
                addr_q <= head.addr;
                rs0_q  <= head.rs0;
                we_n_q <= !head.we;
                do_q   <= head.wdata;
            end else if (clr_we) begin
                we_n_q <= 1'b1;
            end
            if (capture) begin
                rsp_data_q <= DI;
            end
        end
    end

    assign cmd_ready = !full;
    assign A         = addr_q;
    assign RS0       = rs0_q;
    assign we_n      = we_n_q;
    assign DO        = do_q;
    assign CS1       = (state_q == StIssue);
    assign OE        = (state_q == StIssue) && !we_n_q;
    assign rsp_valid = (state_q == StResp);
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != StIdle) || !empty;

`ifdef BUS_INITIATOR_IRQ_EN
    logic irq_s1_q, irq_s2_q, irq_prev_q, irq_pend_q;

    // Synchronizer flops reset high so release of reset never looks like a falling edge.
    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            irq_s1_q   <= 1'b1;
            irq_s2_q   <= 1'b1;
            irq_prev_q <= 1'b1;
            irq_pend_q <= 1'b0;
        end else begin
            irq_s1_q   <= irq_n;
            irq_s2_q   <= irq_s1_q;
            irq_prev_q <= irq_s2_q;
            if (irq_prev_q && !irq_s2_q) begin
                irq_pend_q <= 1'b1;
            end else if (irq_clr) begin
                irq_pend_q <= 1'b0;
            end
        end
    end

    assign irq_pending = irq_pend_q;
`endif

endmodule

// File: tb/tb_bus_initiator_6502.sv
// Self-checking bench for bus_initiator_6502: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of issue order, read latency and handshakes.
module tb_bus_initiator_6502;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT   = 2;

    logic       phi2 = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_we = 1'b0, cmd_rs0 = 1'b0;
    logic [9:0] cmd_addr = 10'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       rsp_ready = 1'b1;
    logic [7:0] DI = 8'd0;
    logic       cmd_ready, rsp_valid, RS0, we_n, CS1, OE, busy;
    logic [7:0] rsp_data, DO;
    logic [9:0] A;
`ifdef BUS_INITIATOR_IRQ_EN
    logic       irq_n = 1'b1, irq_clr = 1'b0, irq_pending;
`endif

    bus_initiator_6502 #(.FIFO_DEPTH(DEPTH), .RD_LAT(LAT)) dut (
        .phi2(phi2), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_rs0(cmd_rs0),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .A(A), .RS0(RS0), .we_n(we_n), .CS1(CS1), .DO(DO), .OE(OE), .DI(DI),
`ifdef BUS_INITIATOR_IRQ_EN
        .irq_n(irq_n), .irq_clr(irq_clr), .irq_pending(irq_pending),
`endif
        .busy(busy)
    );

    always #5 phi2 = ~phi2;

    typedef struct {
        bit       we;
        bit       rs0;
        bit [9:0] addr;
        bit [7:0] wdata;
    } cmd_t;

    cmd_t       q[$];
    int         tests = 0, fails = 0, cyc = 0;
    int         issues = 0, rsps = 0, rd_k = 0;
    bit         outstanding = 0, exp_issue = 0;
    bit [9:0]   rd_addr;
    bit         rd_rs0;
    logic [7:0] di_hist [8192];
    bit         n_valid = 0, n_we = 0, n_rs0 = 0, n_ready = 1, di_force = 0;
    bit [9:0]   n_addr = 0;
    bit [7:0]   n_wdata = 0, di_val = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_A"}, A, 0);
        chk({tag, "_RS0"}, RS0, 0);
        chk({tag, "_we_n"}, we_n, 1);
        chk({tag, "_CS1"}, CS1, 0);
        chk({tag, "_DO"}, DO, 0);
        chk({tag, "_OE"}, OE, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic model_clear();
        q.delete();
        outstanding = 0;
        exp_issue   = 0;
    endtask

    // One bus cycle: drive this cycle's inputs, check outputs, advance the model.
    task automatic step();
        cmd_t h;
        bit   exp_v, ready_m;
        @(posedge phi2);
        #1;
        cyc++;
        cmd_valid = n_valid;
        cmd_we    = n_we;
        cmd_rs0   = n_rs0;
        cmd_addr  = n_addr;
        cmd_wdata = n_wdata;
        rsp_ready = n_ready;
        DI        = di_force ? di_val : 8'($urandom);
        di_hist[cyc % 8192] = DI;

        chk("CS1", CS1, exp_issue);
        if (CS1 && q.size() > 0) begin
            h = q.pop_front();
            issues++;
            chk("issue_we_n", we_n, !h.we);
            chk("issue_A", A, h.addr);
            chk("issue_RS0", RS0, h.rs0);
            chk("issue_OE", OE, h.we);
            if (h.we) begin
                chk("issue_DO", DO, h.wdata);
            end else begin
                outstanding = 1;
                rd_k        = cyc;
                rd_addr     = h.addr;
                rd_rs0      = h.rs0;
            end
        end else begin
            chk("OE_off", OE, 0);
        end
        if (!outstanding && !CS1) chk("we_n_idle", we_n, 1);
        if (outstanding && cyc > rd_k && cyc < rd_k + LAT) begin
            chk("wait_A", A, rd_addr);
            chk("wait_RS0", RS0, rd_rs0);
            chk("wait_we_n", we_n, 1);
        end
        exp_v = outstanding && (cyc >= rd_k + LAT);
        chk("rsp_valid", rsp_valid, exp_v);
        if (exp_v) chk("rsp_data", rsp_data, di_hist[(rd_k + LAT - 1) % 8192]);
        ready_m = (q.size() < DEPTH);
        chk("cmd_ready", cmd_ready, ready_m);
        chk("busy", busy, outstanding || CS1 || q.size() > 0);

        exp_issue = !outstanding && q.size() > 0;
        if (exp_v && rsp_ready) begin
            outstanding = 0;
            rsps++;
        end
        if (cmd_valid && ready_m) q.push_back('{we: n_we, rs0: n_rs0, addr: n_addr, wdata: n_wdata});
    endtask

    task automatic set_cmd(input bit we, input bit rs0, input bit [9:0] addr, input bit [7:0] wd);
        n_valid = 1;
        n_we    = we;
        n_rs0   = rs0;
        n_addr  = addr;
        n_wdata = wd;
    endtask

    initial begin
        int         base_i, base_r, guard;
        logic [7:0] held;

        repeat (2) @(posedge phi2);
        #1;
        chk_reset_vals("por");
        rst_n = 1'b1;
        model_clear();

        // Single write: one ISSUE cycle, no response.
        base_i = issues; base_r = rsps;
        set_cmd(1, 1, 10'h3A5, 8'h5C);
        step();
        n_valid = 0;
        repeat (5) step();
        chk("w_issue_count", issues - base_i, 1);
        chk("w_no_rsp", rsps - base_r, 0);

        // Single read with DI=0xC3.
        base_r = rsps;
        di_force = 1; di_val = 8'hC3;
        set_cmd(0, 0, 10'h004, 8'h00);
        step();
        n_valid = 0;
        repeat (6) step();
        di_force = 0;
        chk("r_rsp_count", rsps - base_r, 1);
        chk("r_rsp_data", rsp_data, 8'hC3);

        // Stall a read response, fill the FIFO with writes, try a fifth push.
        base_i = issues;
        n_ready = 0;
        set_cmd(0, 1, 10'h111, 8'h00);
        step();
        for (int i = 0; i < 5; i++) begin
            set_cmd(1, i[0], 10'(10'h200 + i), 8'(8'hA0 + i));
            step();
        end
        n_valid = 0;
        chk("full_cmd_ready", cmd_ready, 0);
        step();
        n_ready = 1;
        repeat (12) step();
        chk("full_issue_count", issues - base_i, 5);

        // Read then write with the response held off for 5 cycles.
        base_i = issues;
        n_ready = 0;
        set_cmd(0, 0, 10'h0F0, 8'h00);
        step();
        set_cmd(1, 0, 10'h0F1, 8'h77);
        step();
        n_valid = 0;
        guard = 0;
        while (!rsp_valid && guard < 10) begin
            step();
            guard++;
        end
        chk("hold_rsp_seen", rsp_valid, 1);
        held = rsp_data;
        repeat (5) step();
        chk("hold_rsp_stable", rsp_data, held);
        n_ready = 1;
        repeat (6) step();
        chk("hold_issue_count", issues - base_i, 2);

        // Reset asserted during WAIT with two writes queued.
        base_i = issues; base_r = rsps;
        set_cmd(0, 1, 10'h2AA, 8'h00);
        step();
        set_cmd(1, 0, 10'h2AB, 8'h11);
        step();
        set_cmd(1, 1, 10'h2AC, 8'h22);
        step();
        n_valid = 0;
        guard = 0;
        while (!(outstanding && cyc == rd_k + 1) && guard < 10) begin
            step();
            guard++;
        end
        chk("mid_wait_reached", outstanding && cyc == rd_k + 1, 1);
        chk("mid_busy_before", busy, 1);
        cmd_valid = 0;
        rsp_ready = 1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid");
        @(posedge phi2);
        #1;
        cyc++;
        chk_reset_vals("mid_held");
        rst_n = 1'b1;
        model_clear();
        base_i = issues; base_r = rsps;
        repeat (10) step();
        chk("mid_no_issue", issues - base_i, 0);
        chk("mid_no_rsp", rsps - base_r, 0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            n_valid = ($urandom_range(0, 2) != 0);
            n_we    = 1'($urandom);
            n_rs0   = 1'($urandom);
            n_addr  = 10'($urandom);
            n_wdata = 8'($urandom);
            n_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        n_valid = 0;
        n_ready = 1;
        repeat (40) step();
        chk("drain_busy", busy, 0);

`ifdef BUS_INITIATOR_IRQ_EN
        @(posedge phi2);
        #1;
        irq_n = 1'b0;
        repeat (2) begin
            @(posedge phi2);
            #1;
        end
        chk("irq_edge2", irq_pending, 0);
        @(posedge phi2);
        #1;
        chk("irq_edge3", irq_pending, 1);
        irq_n = 1'b1;
        repeat (4) begin
            @(posedge phi2);
            #1;
        end
        chk("irq_rise_keeps", irq_pending, 1);
        irq_n = 1'b0;
        repeat (2) begin
            @(posedge phi2);
            #1;
        end
        irq_clr = 1'b1;
        @(posedge phi2);
        #1;
        irq_clr = 1'b0;
        chk("irq_set_wins", irq_pending, 1);
        irq_clr = 1'b1;
        @(posedge phi2);
        #1;
        irq_clr = 1'b0;
        chk("irq_clr", irq_pending, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_initiator_6502.md
BUS_INITIATOR_6502 -- requirements
Module: bus_initiator_6502

Interface
REQ-001 The block SHALL have one parameter, FIFO_DEPTH: default 4, the command FIFO depth, a power of two in the range 2..16.
REQ-002 The block SHALL have one parameter, RD_LAT: default 2, the number of cycles from read issue to DI sample, in the range 1..4.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with the ports listed in REQ-004 and REQ-005.
REQ-004 Port phi2  in  1  clock; all logic is on the rising edge.
REQ-005 Port rst_n  in  1  asynchronous active-low reset.
REQ-006 Port cmd_valid  in  1  a command is offered.
REQ-007 Port cmd_ready  out  1  the FIFO can accept a command; equals !full.
REQ-008 Port cmd_we  in  1  1 = write, 0 = read.
REQ-009 Port cmd_rs0  in  1  RS0 value for the access.
REQ-010 Port cmd_addr  in  10  target address.
REQ-011 Port cmd_wdata  in  8  write data.
REQ-012 Port rsp_valid  out  1  read data is available.
REQ-013 Port rsp_ready  in  1  the consumer accepts the read data.
REQ-014 Port rsp_data  out  8  captured read data.
REQ-015 Port A  out  10  bus address.
REQ-016 Port RS0  out  1  RAM/IO select.
REQ-017 Port we_n  out  1  bus R/W; 0 = write.
REQ-018 Port CS1  out  1  chip select, active high.
REQ-019 Port DO  out  8  write data driven onto the bus.
REQ-020 Port OE  out  1  drive enable for DB.
REQ-021 Port DI  in  8  bus read data.
REQ-022 Port busy  out  1  set when state != IDLE or the FIFO is non-empty.

Function
REQ-023 A command SHALL be pushed when cmd_valid && cmd_ready; a push while the FIFO is full SHALL be refused and leave the FIFO unchanged.
REQ-024 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-025 In IDLE with the FIFO non-empty, the block SHALL pop the FIFO head, register A/RS0/we_n/DO from it, and enter ISSUE at the next edge.
REQ-026 In ISSUE, CS1 SHALL be 1, and OE SHALL be 1 only for writes; ISSUE SHALL last exactly one cycle.
REQ-027 A write SHALL complete in ISSUE with no response; if the FIFO is non-empty the block SHALL pop again and remain in ISSUE, giving 1 write per cycle.
REQ-028 A read SHALL go from ISSUE to WAIT and sample DI at the end of cycle k+RD_LAT-1, where k is the ISSUE cycle; rsp_valid SHALL be 1 from cycle k+RD_LAT, in RESP.
REQ-029 In WAIT, A, RS0 and we_n SHALL hold their values, and CS1 and OE SHALL be 0.
REQ-030 In RESP, rsp_valid and rsp_data SHALL stay stable until rsp_ready.
REQ-031 On rsp_ready in RESP, rsp_valid SHALL fall at the next edge and the FSM SHALL enter IDLE, giving one bubble cycle.
REQ-032 At most one read SHALL be outstanding, and commands SHALL issue strictly in FIFO order.
REQ-033 Outside ISSUE, CS1 SHALL be 0 and OE SHALL be 0; we_n SHALL be 1 in IDLE.
REQ-034 The FIFO pointers SHALL wrap modulo FIFO_DEPTH, with full/empty distinguished by an extra pointer bit.
REQ-035 A push and a pop in the same cycle SHALL leave the FIFO occupancy unchanged.

Reset
REQ-036 While rst_n is 0, outputs SHALL be: A=0, RS0=0, we_n=1, CS1=0, DO=0, OE=0, rsp_valid=0, rsp_data=0, FIFO empty, state IDLE, cmd_ready=1, busy=0.
REQ-037 Reset asserted mid-operation SHALL discard the FIFO contents and any in-flight read, with no response produced after release.

Configuration
REQ-038 Macro BUS_INITIATOR_IRQ_EN defined SHALL add port irq_n (in 1, from the target), port irq_clr (in 1) and port irq_pending (out 1).
REQ-039 With BUS_INITIATOR_IRQ_EN defined, irq_n SHALL pass through a two-flop synchronizer, and irq_pending SHALL set on a synchronized 1->0 transition.
REQ-040 With BUS_INITIATOR_IRQ_EN defined, irq_pending SHALL clear on irq_clr, set SHALL win when both occur in the same cycle, and irq_pending SHALL reset to 0.
REQ-041 With BUS_INITIATOR_IRQ_EN undefined, these ports and their logic SHALL be absent.

Verification
REQ-042 Write 0x3A5, RS0=1, data 0x5C -> one ISSUE cycle with A=0x3A5, RS0=1, we_n=0, CS1=1, OE=1, DO=0x5C; no rsp_valid.
REQ-043 Read 0x004 with RD_LAT=2 and DI=0xC3 during cycle k+1 -> rsp_valid in cycle k+2 with rsp_data=0xC3; CS1=0 in cycle k+1.
REQ-044 Push 4 writes back-to-back with FIFO_DEPTH=4 -> cmd_ready=0 when full; a 5th push is refused; 4 consecutive ISSUE cycles occur with correct order and no extra.
REQ-045 Read then write with rsp_ready held 0 for 5 cycles -> rsp_data stable; the write does not issue until the cycle after the IDLE bubble following rsp_ready.
REQ-046 rst_n pulsed low during WAIT with 2 queued commands -> all outputs at reset values, and no rsp_valid or ISSUE after release.
REQ-047 With BUS_INITIATOR_IRQ_EN, irq_n falling -> irq_pending=1 at the third edge; irq_clr and a new falling edge in the same cycle -> irq_pending stays 1.
